// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

  // Scoreboard rd field is sized for the widest register file we build.
  // Narrower REG_W values are zero-extended into it; REG_W must not exceed RD_W.
  localparam int RD_W = 8;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            we;
    logic            is_load;
  } sb_entry_t;

  // Empty slot: what a bubble, a flush or reset leaves behind.
  localparam sb_entry_t SB_NOP = '0;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  // Names of the post-decode slots in the default 3-deep pipe.
  localparam int SLOT_E  = 0;
  localparam int SLOT_M  = 1;
  localparam int SLOT_WB = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, stick at all-ones, zero on reset or clear.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller sitting beside decode.
// Tracks in-flight destinations for DEPTH post-decode slots (0 = E ... DEPTH-1 = WB).
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int DEPTH        = 3,
  parameter int REG_W        = 5,
  parameter int LOAD_FWD_MIN = 2,
  parameter int CNT_W        = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_W-1:0]         id_rs1,
  input  logic [REG_W-1:0]         id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [REG_W-1:0]         id_rd,
  input  logic                     id_we,
  input  logic                     id_is_load,
  input  logic                     redirect,
  input  logic                     mem_busy,
  input  logic                     perf_clr,
  output logic                     stall_fd,
  output logic                     bubble_e,
  output logic                     flush_fd,
  output logic                     freeze_all,
  output logic [$clog2(DEPTH)-1:0] fwd_rs1_sel,
  output logic [$clog2(DEPTH)-1:0] fwd_rs2_sel,
  output logic [CNT_W-1:0]         perf_lu_stalls,
  output logic [CNT_W-1:0]         perf_mem_waits,
  output logic [CNT_W-1:0]         perf_flushes
);

  localparam int SEL_W = $clog2(DEPTH);

  sb_entry_t        slot [DEPTH];
  logic [DEPTH-1:0] hit_rs1;
  logic [DEPTH-1:0] hit_rs2;
  logic [SEL_W-1:0] sel_rs1;
  logic [SEL_W-1:0] sel_rs2;
  logic             lu_rs1;
  logic             lu_rs2;
  logic             lu_hazard;
  logic             bubble_int;

  // Per-slot producer match for each source operand; x0 never matches.
  genvar j;
  generate
    for (j = 0; j < DEPTH; j++) begin : g_match
      assign hit_rs1[j] = id_valid && id_use_rs1 && (id_rs1 != '0) && slot[j].valid &&
                          slot[j].we && (slot[j].rd == RD_W'(id_rs1));
      assign hit_rs2[j] = id_valid && id_use_rs2 && (id_rs2 != '0) && slot[j].valid &&
                          slot[j].we && (slot[j].rd == RD_W'(id_rs2));
    end
  endgenerate

  // Youngest producer wins: scan oldest to youngest so the lowest index overrides.
  // A producer already in WB writes the (write-first) regfile, so it selects the regfile.
  always_comb begin
    sel_rs1 = SEL_W'(FWD_RF);
    sel_rs2 = SEL_W'(FWD_RF);
    lu_rs1  = 1'b0;
    lu_rs2  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit_rs1[k]) begin
        lu_rs1  = slot[k].is_load && ((k + 1) < LOAD_FWD_MIN);
        sel_rs1 = (k == DEPTH - 1) ? SEL_W'(FWD_RF) : SEL_W'(k + 1);
      end
      if (hit_rs2[k]) begin
        lu_rs2  = slot[k].is_load && ((k + 1) < LOAD_FWD_MIN);
        sel_rs2 = (k == DEPTH - 1) ? SEL_W'(FWD_RF) : SEL_W'(k + 1);
      end
    end
  end

  assign lu_hazard  = lu_rs1 || lu_rs2;
  // Redirect seen while mem_busy simply waits: E is frozen so the request stays asserted.
  assign bubble_int = !mem_busy && (redirect || lu_hazard || !id_valid);

  assign freeze_all = !reset && mem_busy;
  assign flush_fd   = !reset && redirect && !mem_busy;
  assign stall_fd   = !reset && (mem_busy || (lu_hazard && !redirect));
  assign bubble_e   = !reset && bubble_int;

  // Scoreboard shift and registered forward selects; everything holds while dmem is busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) slot[k] <= SB_NOP;
      fwd_rs1_sel <= SEL_W'(FWD_RF);
      fwd_rs2_sel <= SEL_W'(FWD_RF);
    end else if (!mem_busy) begin
      for (int k = 1; k < DEPTH; k++) slot[k] <= slot[k-1];
      slot[SLOT_E] <= bubble_int ? SB_NOP :
                      sb_entry_t'{valid: 1'b1, rd: RD_W'(id_rd), we: id_we, is_load: id_is_load};
      fwd_rs1_sel  <= bubble_int ? SEL_W'(FWD_RF) : sel_rs1;
      fwd_rs2_sel  <= bubble_int ? SEL_W'(FWD_RF) : sel_rs2;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_lu (
    .clock (clock),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (lu_hazard && !redirect && !mem_busy),
    .count (perf_lu_stalls)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_mem (
    .clock (clock),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (mem_busy),
    .count (perf_mem_waits)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .clock (clock),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (flush_fd),
    .count (perf_flushes)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: default 3-deep instance plus a 4-deep,
// LOAD_FWD_MIN=3 instance with 2-bit counters to reach saturation.
module tb_pipe_hazard_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: DEPTH=3, LOAD_FWD_MIN=2, CNT_W=32
  logic        a_reset, a_valid, a_u1, a_u2, a_we, a_ld, a_redir, a_busy, a_clr;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic        a_stall, a_bubble, a_flush, a_freeze;
  logic [1:0]  a_sel1, a_sel2;
  logic [31:0] a_lu, a_mw, a_fl;

  // Instance B: DEPTH=4, LOAD_FWD_MIN=3, CNT_W=2
  logic        b_reset, b_valid, b_u1, b_u2, b_we, b_ld, b_redir, b_busy, b_clr;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic        b_stall, b_bubble, b_flush, b_freeze;
  logic [1:0]  b_sel1, b_sel2;
  logic [1:0]  b_lu, b_mw, b_fl;

  pipe_hazard_unit #(.DEPTH(3), .REG_W(5), .LOAD_FWD_MIN(2), .CNT_W(32)) dut_a (
    .clock(clock), .reset(a_reset), .id_valid(a_valid), .id_rs1(a_rs1), .id_rs2(a_rs2),
    .id_use_rs1(a_u1), .id_use_rs2(a_u2), .id_rd(a_rd), .id_we(a_we), .id_is_load(a_ld),
    .redirect(a_redir), .mem_busy(a_busy), .perf_clr(a_clr),
    .stall_fd(a_stall), .bubble_e(a_bubble), .flush_fd(a_flush), .freeze_all(a_freeze),
    .fwd_rs1_sel(a_sel1), .fwd_rs2_sel(a_sel2),
    .perf_lu_stalls(a_lu), .perf_mem_waits(a_mw), .perf_flushes(a_fl)
  );

  pipe_hazard_unit #(.DEPTH(4), .REG_W(5), .LOAD_FWD_MIN(3), .CNT_W(2)) dut_b (
    .clock(clock), .reset(b_reset), .id_valid(b_valid), .id_rs1(b_rs1), .id_rs2(b_rs2),
    .id_use_rs1(b_u1), .id_use_rs2(b_u2), .id_rd(b_rd), .id_we(b_we), .id_is_load(b_ld),
    .redirect(b_redir), .mem_busy(b_busy), .perf_clr(b_clr),
    .stall_fd(b_stall), .bubble_e(b_bubble), .flush_fd(b_flush), .freeze_all(b_freeze),
    .fwd_rs1_sel(b_sel1), .fwd_rs2_sel(b_sel2),
    .perf_lu_stalls(b_lu), .perf_mem_waits(b_mw), .perf_flushes(b_fl)
  );

  typedef struct {
    int       idx;
    bit       d;
    bit [3:0] eo;   // {stall_fd, bubble_e, flush_fd, freeze_all}
    int       s1;
    int       s2;
    int       clu;
    int       cmw;
    int       cfl;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_no   = 0;

  exp_t     m_e;
  bit [3:0] m_eo;
  int       m_s1, m_s2, m_lu, m_mw, m_fl;

  // Monitor: every negedge the DUT presents a cycle's outputs; pop and compare.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      if (!m_e.d) begin
        m_eo = {a_stall, a_bubble, a_flush, a_freeze};
        m_s1 = int'(a_sel1); m_s2 = int'(a_sel2);
        m_lu = int'(a_lu);   m_mw = int'(a_mw);   m_fl = int'(a_fl);
      end else begin
        m_eo = {b_stall, b_bubble, b_flush, b_freeze};
        m_s1 = int'(b_sel1); m_s2 = int'(b_sel2);
        m_lu = int'(b_lu);   m_mw = int'(b_mw);   m_fl = int'(b_fl);
      end
      n_checks++;
      if (m_eo !== m_e.eo) begin
        n_fail++;
        $display("FAIL vec%0d dut%0d ctl {stall,bubble,flush,freeze}: got %b want %b",
                 m_e.idx, m_e.d, m_eo, m_e.eo);
      end
      n_checks++;
      if (m_s1 != m_e.s1 || m_s2 != m_e.s2) begin
        n_fail++;
        $display("FAIL vec%0d dut%0d fwd_sel: got %0d/%0d want %0d/%0d",
                 m_e.idx, m_e.d, m_s1, m_s2, m_e.s1, m_e.s2);
      end
      n_checks++;
      if (m_lu != m_e.clu || m_mw != m_e.cmw || m_fl != m_e.cfl) begin
        n_fail++;
        $display("FAIL vec%0d dut%0d perf lu/mw/fl: got %0d/%0d/%0d want %0d/%0d/%0d",
                 m_e.idx, m_e.d, m_lu, m_mw, m_fl, m_e.clu, m_e.cmw, m_e.cfl);
      end
    end
  end

  // Drive one cycle of inputs on the selected instance and queue its expected response.
  task automatic cyc(input bit d, input bit rst, input bit v, input int rs1, input int rs2,
                     input bit u1, input bit u2, input int rd, input bit we, input bit ld,
                     input bit rdr, input bit busy, input bit clr, input bit [3:0] eo,
                     input int s1, input int s2, input int clu, input int cmw, input int cfl);
    exp_t e;
    if (!d) begin
      a_reset = rst; a_valid = v; a_rs1 = 5'(rs1); a_rs2 = 5'(rs2); a_u1 = u1; a_u2 = u2;
      a_rd = 5'(rd); a_we = we; a_ld = ld; a_redir = rdr; a_busy = busy; a_clr = clr;
    end else begin
      b_reset = rst; b_valid = v; b_rs1 = 5'(rs1); b_rs2 = 5'(rs2); b_u1 = u1; b_u2 = u2;
      b_rd = 5'(rd); b_we = we; b_ld = ld; b_redir = rdr; b_busy = busy; b_clr = clr;
    end
    e.idx = vec_no; e.d = d; e.eo = eo; e.s1 = s1; e.s2 = s2;
    e.clu = clu; e.cmw = cmw; e.cfl = cfl;
    q.push_back(e);
    vec_no++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    a_reset = 1; a_valid = 0; a_rs1 = 0; a_rs2 = 0; a_u1 = 0; a_u2 = 0; a_rd = 0;
    a_we = 0; a_ld = 0; a_redir = 0; a_busy = 0; a_clr = 0;
    b_reset = 1; b_valid = 0; b_rs1 = 0; b_rs2 = 0; b_u1 = 0; b_u2 = 0; b_rd = 0;
    b_we = 0; b_ld = 0; b_redir = 0; b_busy = 0; b_clr = 0;
    repeat (2) @(posedge clock);
    #1;
    b_reset = 0;

    //  d rst v rs1 rs2 u1 u2 rd we ld rdr busy clr  eo(S B F Z) s1 s2 lu mw fl
    cyc(0, 1, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0,   0, 4'b0000, 0, 0, 0, 0, 0);
    // add x5,x1,x2 ; add x6,x5,x0 -> ALU forward from E
    cyc(0, 0, 1,  1,  2, 1, 1,  5, 1, 0, 0,  0,   0, 4'b0000, 0, 0, 0, 0, 0);
    cyc(0, 0, 1,  5,  0, 1, 1,  6, 1, 0, 0,  0,   0, 4'b0000, 0, 0, 0, 0, 0);
    cyc(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0,   0, 4'b0100, 1, 0, 0, 0, 0);
    // lw x5,0(x1) ; add x7,x5,x5 -> one stall, then forward from M
    cyc(0, 0, 1,  1,  0, 1, 0,  5, 1, 1, 0,  0,   0, 4'b0000, 0, 0, 0, 0, 0);
    cyc(0, 0, 1,  5,  5, 1, 1,  7, 1, 0, 0,  0,   0, 4'b1100, 0, 0, 0, 0, 0);
    cyc(0, 0, 1,  5,  5, 1, 1,  7, 1, 0, 0,  0,   0, 4'b0000, 0, 0, 1, 0, 0);
    // addi x0,x0,1 ; add x3,x0,x0 -> x0 never forwards
    cyc(0, 0, 1,  0,  0, 1, 0,  0, 1, 0, 0,  0,   0, 4'b0000, 2, 2, 1, 0, 0);
    cyc(0, 0, 1,  0,  0, 1, 1,  3, 1, 0, 0,  0,   0, 4'b0000, 0, 0, 1, 0, 0);
    // lw x8,0(x3) ; add x9,x8,x1 with redirect -> redirect beats load-use
    cyc(0, 0, 1,  3,  0, 1, 0,  8, 1, 1, 0,  0,   0, 4'b0000, 0, 0, 1, 0, 0);
    cyc(0, 0, 1,  8,  1, 1, 1,  9, 1, 0, 1,  0,   0, 4'b0110, 1, 0, 1, 0, 0);
    cyc(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0,   0, 4'b0100, 0, 0, 1, 0, 1);
    // fill pipe with x10, x11, then freeze 3 cycles with a pending redirect
    cyc(0, 0, 1,  2,  2, 1, 1, 10, 1, 0, 0,  0,   0, 4'b0000, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 10, 10, 1, 1, 11, 1, 0, 0,  0,   0, 4'b0000, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 11, 10, 1, 1, 12, 1, 0, 1,  1,   0, 4'b1001, 1, 1, 1, 0, 1);
    cyc(0, 0, 1, 11, 10, 1, 1, 12, 1, 0, 1,  1,   0, 4'b1001, 1, 1, 1, 1, 1);
    cyc(0, 0, 1, 11, 10, 1, 1, 12, 1, 0, 1,  1,   0, 4'b1001, 1, 1, 1, 2, 1);
    cyc(0, 0, 1, 11, 10, 1, 1, 12, 1, 0, 1,  0,   0, 4'b0110, 1, 1, 1, 3, 1);
    // slots advanced exactly once across the freeze: x11 at M (sel 2), x10 at WB (regfile)
    cyc(0, 0, 1, 11, 10, 1, 1, 13, 1, 0, 0,  0,   0, 4'b0000, 0, 0, 1, 3, 2);
    cyc(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0,   0, 4'b0100, 2, 0, 1, 3, 2);
    // clear beats increment, then reset during freeze with redirect pending
    cyc(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0,  1,   1, 4'b1001, 0, 0, 1, 3, 2);
    cyc(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 1,  1,   0, 4'b1001, 0, 0, 0, 0, 0);
    cyc(0, 1, 0,  0,  0, 0, 0,  0, 0, 0, 1,  1,   0, 4'b0000, 0, 0, 0, 1, 0);
    // x13 was in M before reset; it must be gone now
    cyc(0, 0, 1, 13,  0, 1, 0, 14, 1, 0, 0,  0,   0, 4'b0000, 0, 0, 0, 0, 0);
    cyc(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0,   0, 4'b0100, 0, 0, 0, 0, 0);
    a_valid = 0; a_redir = 0; a_busy = 0; a_clr = 0;

    // DEPTH=4, LOAD_FWD_MIN=3: two stall cycles then forward from slot 3
    cyc(1, 1, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0,   0, 4'b0000, 0, 0, 0, 0, 0);
    cyc(1, 0, 1,  1,  0, 1, 0,  5, 1, 1, 0,  0,   0, 4'b0000, 0, 0, 0, 0, 0);
    cyc(1, 0, 1,  5,  5, 1, 1,  7, 1, 0, 0,  0,   0, 4'b1100, 0, 0, 0, 0, 0);
    cyc(1, 0, 1,  5,  5, 1, 1,  7, 1, 0, 0,  0,   0, 4'b1100, 0, 0, 1, 0, 0);
    cyc(1, 0, 1,  5,  5, 1, 1,  7, 1, 0, 0,  0,   0, 4'b0000, 0, 0, 2, 0, 0);
    cyc(1, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0,   0, 4'b0100, 3, 3, 2, 0, 0);
    // 2-bit mem-wait counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1001, 0, 0, 2, (i < 3) ? i : 3, 0);
    end
    cyc(1, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0,   0, 4'b0100, 0, 0, 2, 3, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
